// File: rtl/aes_if_pkg.sv
// Shared definitions for the AES-128 host interface blocks: block width,
// output FSM state encoding and the legal output word width check.
package aes_if_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } outif_state_t;

  function automatic bit legal_word_w(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/aes_output_interface.sv
// Captures a 128-bit cipher result and streams it out MSW-first as WORD_W words
// over valid/ready. Optional even parity on out_word when OUTIF_PARITY_EN is defined.
module aes_output_interface
  import aes_if_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_done,
  input  logic [AES_BLOCK_W-1:0] core_result,
  output logic [WORD_W-1:0]      out_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clr_err
`ifdef OUTIF_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int NWORDS = AES_BLOCK_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BASE_W = $clog2(AES_BLOCK_W);

  if (!legal_word_w(WORD_W)) begin : g_bad_word_w
    $error("aes_output_interface: WORD_W must be 8, 16, 32, 64 or 128");
  end

  outif_state_t           state_p0, state_nxt;
  logic [AES_BLOCK_W-1:0] buf_p0, buf_nxt;
  logic [IDX_W-1:0]       idx_p0, idx_nxt;
  logic                   overrun_p0, overrun_nxt;
  logic                   vld_p0;
  logic                   last_p0;
  logic                   xfer;
  logic [BASE_W-1:0]      base_p0;

  // Stage p0: registered block buffer, word index, state and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= IDLE;
      buf_p0     <= '0;
      idx_p0     <= '0;
      overrun_p0 <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      buf_p0     <= buf_nxt;
      idx_p0     <= idx_nxt;
      overrun_p0 <= overrun_nxt;
    end
  end

  assign vld_p0  = (state_p0 == SEND);
  assign last_p0 = (idx_p0 == IDX_W'(NWORDS - 1));
  assign xfer    = vld_p0 && out_ready;

  always_comb begin
    state_nxt   = state_p0;
    buf_nxt     = buf_p0;
    idx_nxt     = idx_p0;
    overrun_nxt = overrun_p0;
    if (clr_err) overrun_nxt = 1'b0;
    case (state_p0)
      IDLE: begin
        if (core_done) begin
          buf_nxt   = core_result;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (xfer && last_p0) begin
          idx_nxt = '0;
          // A completion landing on the final transfer chains straight into the next block
          if (core_done) buf_nxt = core_result;
          else           state_nxt = IDLE;
        end else begin
          if (xfer) idx_nxt = idx_p0 + IDX_W'(1);
          if (core_done) overrun_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: all outputs derive from p0 registers only
  always_comb begin
    base_p0 = BASE_W'((NWORDS - 1 - int'(idx_p0)) * WORD_W);
  end

  assign out_word  = vld_p0 ? buf_p0[base_p0 +: WORD_W] : '0;
  assign out_valid = vld_p0;
  assign out_last  = vld_p0 && last_p0;
  assign busy      = vld_p0;
  assign overrun   = overrun_p0;

`ifdef OUTIF_PARITY_EN
  assign out_parity = ^out_word;
`endif

endmodule

// File: tb/tb_aes_output_interface.sv
// Directed bench for aes_output_interface (WORD_W=32): drain, backpressure,
// overrun, back-to-back, async reset, and parity when OUTIF_PARITY_EN is defined.
module tb_aes_output_interface;
  import aes_if_pkg::*;

  localparam int WORD_W = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   core_done = 1'b0;
  logic [AES_BLOCK_W-1:0] core_result = '0;
  logic [WORD_W-1:0]      out_word;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic                   out_last;
  logic                   busy;
  logic                   overrun;
  logic                   clr_err = 1'b0;
`ifdef OUTIF_PARITY_EN
  logic                   out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  aes_output_interface #(.WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_done   (core_done),
    .core_result (core_result),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_err     (clr_err)
`ifdef OUTIF_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic last);
    chk({tag, " valid"}, out_valid, 1'b1);
    chk({tag, " word"},  out_word,  w);
    chk({tag, " last"},  out_last,  last);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst valid", out_valid, 1'b0);
    chk("rst word",  out_word,  32'h0);
    chk("rst last",  out_last,  1'b0);
    chk("rst busy",  busy,      1'b0);
    chk("rst ovr",   overrun,   1'b0);
`ifdef OUTIF_PARITY_EN
    chk("rst parity", out_parity, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step();

    // basic drain
    out_ready   = 1'b1;
    core_done   = 1'b1;
    core_result = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step();
    core_done = 1'b0;
    chk_word("drain w0", 32'h00112233, 1'b0);
    chk("drain busy", busy, 1'b1);
`ifdef OUTIF_PARITY_EN
    chk("parity 00112233", out_parity, 1'b0);
`endif
    step(); chk_word("drain w1", 32'h44556677, 1'b0);
    step(); chk_word("drain w2", 32'h8899AABB, 1'b0);
    step(); chk_word("drain w3", 32'hCCDDEEFF, 1'b1);
    step();
    chk("drain end valid", out_valid, 1'b0);
    chk("drain end busy",  busy,      1'b0);
    chk("drain end last",  out_last,  1'b0);
`ifdef OUTIF_PARITY_EN
    chk("idle parity", out_parity, 1'b0);
`endif

    // backpressure on word 1
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk_word("bp w0", 32'h00112233, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_word("bp hold", 32'h44556677, 1'b0);
      step();
    end
    chk_word("bp hold end", 32'h44556677, 1'b0);
    out_ready = 1'b1;
    step(); chk_word("bp w2", 32'h8899AABB, 1'b0);
    step(); chk_word("bp w3", 32'hCCDDEEFF, 1'b1);
    step(); chk("bp end busy", busy, 1'b0);

    // overrun while word 2 is stalled
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step(); step();
    chk_word("ovr w2 pre", 32'h8899AABB, 1'b0);
    out_ready   = 1'b0;
    core_done   = 1'b1;
    core_result = {4{32'hAAAAAAAA}};
    step();
    core_done = 1'b0;
    chk("ovr set", overrun, 1'b1);
    chk_word("ovr w2 kept", 32'h8899AABB, 1'b0);
    out_ready = 1'b1;
    step();
    chk_word("ovr w3", 32'hCCDDEEFF, 1'b1);
    // clear and new overrun in the same cycle: set wins
    out_ready = 1'b0;
    core_done = 1'b1;
    clr_err   = 1'b1;
    step();
    core_done = 1'b0;
    clr_err   = 1'b0;
    chk("ovr set wins", overrun, 1'b1);
    chk_word("ovr w3 kept", 32'hCCDDEEFF, 1'b1);
    out_ready = 1'b1;
    step();
    chk("ovr idle busy", busy,    1'b0);
    chk("ovr sticky",    overrun, 1'b1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovr cleared", overrun, 1'b0);

    // back-to-back blocks
    core_done   = 1'b1;
    core_result = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    step();
    core_done = 1'b0;
    step(); step(); step();
    chk_word("b2b a3", 32'h0D0E0F10, 1'b1);
    core_done   = 1'b1;
    core_result = 128'h00000001_11111111_22222222_33333333;
    step();
    core_done = 1'b0;
    chk_word("b2b b0", 32'h00000001, 1'b0);
    chk("b2b ovr", overrun, 1'b0);
`ifdef OUTIF_PARITY_EN
    chk("parity 00000001", out_parity, 1'b1);
`endif
    step(); chk_word("b2b b1", 32'h11111111, 1'b0);
    step(); chk_word("b2b b2", 32'h22222222, 1'b0);
    step(); chk_word("b2b b3", 32'h33333333, 1'b1);
    step(); chk("b2b end busy", busy, 1'b0);

    // asynchronous reset mid-block
    core_done   = 1'b1;
    core_result = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    step();
    core_done = 1'b0;
    step(); step();
    chk_word("rst w2 pre", 32'h8899AABB, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst valid", out_valid, 1'b0);
    chk("arst last",  out_last,  1'b0);
    chk("arst busy",  busy,      1'b0);
    chk("arst word",  out_word,  32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post rst idle", out_valid, 1'b0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk_word("post rst w0", 32'h00112233, 1'b0);
    step(); chk_word("post rst w1", 32'h44556677, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_output_interface.md
# aes_output_interface

Output-side counterpart of the AES-128 input interface. Captures the 128-bit result block from the cipher core when the core signals completion, holds it in a local buffer, and streams it to the host as WORD_W-bit words over a valid/ready handshake, most-significant word first. Flags any completion that arrives while a previous block is still being drained.

## Interface
Parameters:
- WORD_W, 32, output word width; legal values 8, 16, 32, 64, 128.
- NWORDS, 128/WORD_W, derived localparam; words per block.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- core_done  in  1  one-cycle pulse; core_result is valid in the same cycle.
- core_result  in  128  ciphertext/plaintext block from the cipher core.
- out_word  out  WORD_W  current output word.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  host accepts out_word this cycle.
- out_last  out  1  out_word is the final word of the block.
- busy  out  1  a block is being drained.
- overrun  out  1  sticky flag: a completion was dropped.
- clr_err  in  1  synchronous clear of overrun.
- out_parity  out  1  present only with OUTIF_PARITY_EN.

## Operation
- FSM states: IDLE, SEND.
- IDLE: on core_done, load buffer <= core_result, idx <= 0, go to SEND. Otherwise hold.
- SEND: out_valid = 1. out_word = buffer[127 - idx*WORD_W -: WORD_W]. out_last = (idx == NWORDS-1).
- Transfer occurs on out_valid && out_ready. Non-last word: idx++. Last word: go to IDLE and zero idx.
- Transfer of the last word in the same cycle as core_done: accept the new block (reload buffer, idx <= 0, stay in SEND). This is not an overrun.
- core_done in SEND without a last-word transfer: the block is dropped, buffer is unchanged, and overrun <= 1.
- overrun is sticky. clr_err clears it. If clr_err and a new overrun event occur in the same cycle, the set wins.
- busy = (state == SEND). Outputs are registered or decoded from registered state only, with no combinational path from out_ready to out_valid.
- Holding rule: while out_valid && !out_ready, out_word and out_last stay stable.
- With NWORDS = 1, every word is the last word.

## Timing
- Reset values: state IDLE, buffer 0, idx 0, out_word 0, out_valid 0, out_last 0, busy 0, overrun 0, out_parity 0.
- Latency: core_done in cycle N gives out_valid = 1 with word 0 in cycle N+1.
- With out_ready held high, one word transfers per cycle. The last word is in cycle N+NWORDS, and out_valid drops in cycle N+NWORDS+1.
- Back-to-back blocks: when core_done coincides with the last transfer, there is zero bubble, and word 0 of the new block appears the next cycle.
- Reset mid-block aborts immediately: the partial block is discarded and all outputs return to reset values asynchronously.

## Configuration
- OUTIF_PARITY_EN defined:
  - out_parity port exists and equals ^out_word, even parity over the current word.
  - It is 0 when out_valid is 0.
  - It follows the holding rule.
- OUTIF_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package aes_if_pkg holds:
  - AES_BLOCK_W = 128.
  - the outif_state_t enum (IDLE, SEND).
  - a function for the legal WORD_W check, which is asserted at elaboration.
- No sub-module is warranted. The word select is a single indexed part-select, so the block stays one module of about 150 lines.

## Test plan
- Basic drain:
  - Stimulus: WORD_W=32; core_done with core_result=128'h00112233_44556677_8899AABB_CCDDEEFF; out_ready=1.
  - Required: words 00112233, 44556677, 8899AABB, CCDDEEFF in cycles N+1..N+4; out_last only in N+4; busy=0 at N+5.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while word 1 is presented.
  - Required: out_word holds 44556677 with out_valid=1 throughout; the sequence resumes unchanged.
- Overrun:
  - Stimulus: second core_done (result AAAA...) during word 2.
  - Required: remaining words still 8899AABB, CCDDEEFF; overrun=1 next cycle and stays set.
  - Stimulus: clr_err pulse. Required: overrun returns to 0.
- Back-to-back:
  - Stimulus: core_done coincident with the last-word transfer.
  - Required: new word 0 in the next cycle, no idle cycle, overrun stays 0.
- Reset mid-block:
  - Stimulus: rst asserted during word 2.
  - Required: out_valid, out_last and busy are 0 immediately; the next core_done restarts at word 0.
- Parity (OUTIF_PARITY_EN defined):
  - Required: out_parity is 0 for 00112233 and 1 for 00000001.
  - Required: out_parity is 0 while idle.
